// File: rtl/adc_dec_pkg.sv
// rtl/adc_dec_pkg.sv - shared state encoding and code-range helpers for the ADC offset decoder
package adc_dec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CAL  = 2'd1,
    ST_RUN  = 2'd2
  } dec_state_e;

  // Mid-scale code of an offset-binary converter of the given width.
  function automatic int unsigned mid_code(input int unsigned width);
    return 32'd1 << (width - 1);
  endfunction

  function automatic int unsigned top_code(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/adc_offset_decoder.sv
// rtl/adc_offset_decoder.sv - calibrates ADC mid-scale offset by averaging, then emits signed offset-corrected samples
module adc_offset_decoder
  import adc_dec_pkg::*;
#(
  parameter int WIDTH    = 12,
  parameter int CAL_LOG2 = 6,
  parameter int OFS_LIM  = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cal_start,
  input  logic                    in_valid,
  input  logic [WIDTH-1:0]        in_code,
  output logic                    out_valid,
  output logic signed [WIDTH:0]   out_data,
  output logic                    rail,
  output logic                    cal_done,
  output logic                    cal_err,
  output logic [WIDTH-1:0]        offset
);

  localparam int ACC_W = WIDTH + CAL_LOG2;
  localparam int CNT_W = CAL_LOG2 + 1;
  localparam logic [WIDTH-1:0] MID      = WIDTH'(mid_code(WIDTH));
  localparam logic [WIDTH-1:0] TOP      = WIDTH'(top_code(WIDTH));
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << CAL_LOG2) - 1);
  localparam logic [WIDTH:0]   LIM      = (WIDTH+1)'(OFS_LIM);

  dec_state_e                state_q, state_d;
  logic [ACC_W-1:0]          acc_q, acc_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0]          offset_q, offset_d;
  logic                      cal_err_q, cal_err_d;
  logic                      out_valid_q, out_valid_d;
  logic signed [WIDTH:0]     out_data_q, out_data_d;
  logic                      rail_q, rail_d;

  logic [ACC_W-1:0]          acc_sum;
  logic [WIDTH-1:0]          avg;
  logic signed [WIDTH:0]     dev;
  logic [WIDTH:0]            dev_mag;

  assign acc_sum = acc_q + ACC_W'(in_code);
  assign avg     = acc_sum[ACC_W-1:CAL_LOG2];
  assign dev     = $signed({1'b0, avg}) - $signed({1'b0, MID});
  assign dev_mag = dev[WIDTH] ? $unsigned(-dev) : $unsigned(dev);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      offset_q    <= MID;
      cal_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      rail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      offset_q    <= offset_d;
      cal_err_q   <= cal_err_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      rail_q      <= rail_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    offset_d    = offset_q;
    cal_err_d   = cal_err_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    rail_d      = rail_q;

    // A (re)start seeds the new calibration with any sample arriving in the same cycle.
    if (cal_start) begin
      state_d = ST_CAL;
      acc_d   = in_valid ? ACC_W'(in_code) : '0;
      cnt_d   = in_valid ? CNT_W'(1) : '0;
    end else begin
      unique case (state_q)
        ST_CAL: begin
          if (in_valid) begin
            if (cnt_q == CNT_LAST) begin
              state_d = ST_RUN;
              acc_d   = '0;
              cnt_d   = '0;
              if (dev_mag > LIM) begin
                offset_d  = MID;
                cal_err_d = 1'b1;
              end else begin
                offset_d  = avg;
                cal_err_d = 1'b0;
              end
            end else begin
              acc_d = acc_sum;
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_RUN: begin
          if (in_valid) begin
            out_valid_d = 1'b1;
            out_data_d  = $signed({1'b0, in_code}) - $signed({1'b0, offset_q});
            rail_d      = (in_code == '0) || (in_code == TOP);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign rail      = rail_q;
  assign cal_done  = (state_q == ST_RUN);
  assign cal_err   = cal_err_q;
  assign offset    = offset_q;

endmodule
